bridge_ctrl: RTL and testbench

//  Multi-cycle bridge sequencer between the M stage and memory-mapped devices.

---
 rtl/bridge_pkg.sv | 23 ++
 rtl/bridge_addr_dec.sv | 25 ++
 rtl/bridge_ctrl.sv | 150 +++++++++++++++
 tb/tb_bridge_ctrl.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared types and constants for the M-stage device bridge.
// Optional abort-on-timeout is enabled with BRIDGE_TIMEOUT_EN.
package bridge_pkg;

    localparam int BRIDGE_SLOT_BITS = 4;
    localparam int IDX_W = 2;
    localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    function automatic logic [31-BRIDGE_SLOT_BITS:0] slot_hi(
        input logic [31:0] base0,
        input int          i
    );
        return (32-BRIDGE_SLOT_BITS)'(
            (base0 + (32'(i) << BRIDGE_SLOT_BITS)) >> BRIDGE_SLOT_BITS);
    endfunction

endpackage

// File: rtl/bridge_addr_dec.sv
// Device slot decoder: upper address bits -> one-hot hit and slot index.
// Slots are 16 bytes apart starting at DEV0_BASE.
import bridge_pkg::*;

module bridge_addr_dec #(
    parameter int          N_DEV     = 2,
    parameter logic [31:0] DEV0_BASE = 32'h7F00
) (
    input  logic [31-BRIDGE_SLOT_BITS:0] addr_hi,
    output logic [N_DEV-1:0]             hit,
    output logic [IDX_W-1:0]             idx
);

    always_comb begin
        hit = '0;
        idx = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (addr_hi == slot_hi(DEV0_BASE, i)) begin
                hit[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bridge_ctrl.sv
// M-stage bridge sequencer: stalls the pipe while a device access runs.
// Define BRIDGE_TIMEOUT_EN to abort stuck accesses after TIMEOUT BUSY cycles.
import bridge_pkg::*;

module bridge_ctrl #(
    parameter int          N_DEV     = 2,
    parameter logic [31:0] DEV0_BASE = 32'h7F00,
    parameter int          TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          PrAddr,
    input  logic [31:0]          PrWD,
    input  logic                 PrWE,
    input  logic                 PrRE,
    input  logic                 Flush,
    output logic [31:0]          PrRD,
    output logic                 DataOsel,
    output logic                 Stall,
    output logic                 BusErr,
    output logic [N_DEV-1:0]     DevSel,
    output logic                 DevWE,
    output logic [3:0]           DevAddr,
    output logic [31:0]          DevWD,
    input  logic [32*N_DEV-1:0]  DevRD,
    input  logic [N_DEV-1:0]     DevReady
);

    state_t            state, state_n;
    logic [N_DEV-1:0]  hit;
    logic [IDX_W-1:0]  idx, idx_q;
    logic              we_q;
    logic              start;
    logic              capture;
    logic              dev_ready;
    logic [31:0]       dev_rd;
    logic              tmo;

    bridge_addr_dec #(
        .N_DEV     (N_DEV),
        .DEV0_BASE (DEV0_BASE)
    ) u_dec (
        .addr_hi (PrAddr[31:BRIDGE_SLOT_BITS]),
        .hit     (hit),
        .idx     (idx)
    );

    always_comb begin
        dev_ready = 1'b0;
        dev_rd    = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (idx_q == IDX_W'(i)) begin
                dev_ready = DevReady[i];
                dev_rd    = DevRD[32*i +: 32];
            end
        end
    end

`ifdef BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;
    logic             bus_err_q;

    assign tmo    = (cnt == CNT_W'(TIMEOUT - 1));
    assign BusErr = bus_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (start)
                cnt <= '0;
            else if (state == ST_BUSY)
                cnt <= cnt + 1'b1;
            bus_err_q <= (state == ST_BUSY) && !Flush && !dev_ready && tmo;
        end
    end
`else
    assign tmo    = 1'b0;
    assign BusErr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n  = state;
        start    = 1'b0;
        capture  = 1'b0;
        Stall    = 1'b0;
        DataOsel = 1'b0;
        DevWE    = 1'b0;
        DevSel   = '0;
        unique case (state)
            ST_IDLE: begin
                start = (PrWE | PrRE) && (|hit) && !Flush;
                Stall = start;
                if (start)
                    state_n = ST_BUSY;
            end
            ST_BUSY: begin
                Stall = 1'b1;
                DevWE = we_q;
                for (int i = 0; i < N_DEV; i++)
                    DevSel[i] = (idx_q == IDX_W'(i));
                // A flushed instruction never gets data, even if Ready arrives.
                if (Flush) begin
                    state_n = ST_IDLE;
                end else if (dev_ready) begin
                    capture = 1'b1;
                    state_n = ST_DONE;
                end else if (tmo) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                DataOsel = 1'b1;
                state_n  = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q   <= '0;
            we_q    <= 1'b0;
            DevAddr <= '0;
            DevWD   <= '0;
            PrRD    <= '0;
        end else begin
            if (start) begin
                idx_q   <= idx;
                we_q    <= PrWE;
                DevAddr <= PrAddr[3:0];
                DevWD   <= PrWD;
            end
            if (capture)
                PrRD <= we_q ? 32'h0 : dev_rd;
            else if (state == ST_BUSY && !Flush && tmo)
                PrRD <= BUS_ERR_DATA;
        end
    end

endmodule

// File: tb/tb_bridge_ctrl.sv
// Scoreboard bench for bridge_ctrl: expected PrRD queued at issue, checked in DONE.
module tb_bridge_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PrAddr, PrWD, PrRD, DevWD;
    logic        PrWE, PrRE, Flush;
    logic        DataOsel, Stall, BusErr, DevWE;
    logic [1:0]  DevSel, DevReady;
    logic [3:0]  DevAddr;
    logic [63:0] DevRD;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb[$];
    logic [31:0] last_rd;
    logic [31:0] exp_rd;

    always #5 clk = ~clk;

    bridge_ctrl #(
        .N_DEV     (2),
        .DEV0_BASE (32'h7F00),
        .TIMEOUT   (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .PrAddr   (PrAddr),
        .PrWD     (PrWD),
        .PrWE     (PrWE),
        .PrRE     (PrRE),
        .Flush    (Flush),
        .PrRD     (PrRD),
        .DataOsel (DataOsel),
        .Stall    (Stall),
        .BusErr   (BusErr),
        .DevSel   (DevSel),
        .DevWE    (DevWE),
        .DevAddr  (DevAddr),
        .DevWD    (DevWD),
        .DevRD    (DevRD),
        .DevReady (DevReady)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; PrAddr = '0; PrWD = '0; PrWE = 1'b0; PrRE = 1'b0;
        Flush = 1'b0; DevRD = '0; DevReady = '0;
        tick; tick;
        reset = 1'b0;
        settle;
        checks++;
        if ({Stall, DataOsel, BusErr, DevWE, DevSel} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl got=%b exp=000000",
                     {Stall, DataOsel, BusErr, DevWE, DevSel});
        end
        checks++;
        if ({PrRD, DevWD, DevAddr} !== 68'h0) begin
            errors++;
            $display("FAIL reset_data got=%h/%h/%h exp=0",
                     PrRD, DevWD, DevAddr);
        end
        last_rd = 32'h0;
    endtask

    task automatic test_load_dev0;
        tick;
        PrRE = 1'b1; PrAddr = 32'h7F04;
        DevRD[31:0] = 32'h1234; DevReady = 2'b01;
        sb.push_back(32'h1234);
        settle;
        checks++;
        if ({Stall, DevSel} !== 3'b100) begin
            errors++;
            $display("FAIL ld0_idle got=%b exp=100", {Stall, DevSel});
        end
        tick; settle;
        checks++;
        if ({Stall, DevWE, DevSel, DevAddr} !== {1'b1, 1'b0, 2'b01, 4'd4}) begin
            errors++;
            $display("FAIL ld0_busy got=%b exp=10010100",
                     {Stall, DevWE, DevSel, DevAddr});
        end
        tick; settle;
        checks++;
        if ({Stall, DataOsel} !== 2'b01) begin
            errors++;
            $display("FAIL ld0_done got=%b exp=01", {Stall, DataOsel});
        end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL ld0_sb got=empty exp=entry");
        end else begin
            exp_rd = sb.pop_front();
            last_rd = exp_rd;
            checks++;
            if (PrRD !== exp_rd) begin
                errors++;
                $display("FAIL ld0_rd got=%h exp=%h", PrRD, exp_rd);
            end
        end
        PrRE = 1'b0;
        tick; settle;
        checks++;
        if ({Stall, DataOsel, DevSel} !== 4'b0) begin
            errors++;
            $display("FAIL ld0_after got=%b exp=0000",
                     {Stall, DataOsel, DevSel});
        end
    endtask

    task automatic test_store_dev1;
        tick;
        PrWE = 1'b1; PrAddr = 32'h7F18; PrWD = 32'hCAFE;
        DevRD[63:32] = 32'h5555; DevReady = 2'b00;
        sb.push_back(32'h0);
        settle;
        checks++;
        if (Stall !== 1'b1) begin
            errors++;
            $display("FAIL st_idle_stall got=%b exp=1", Stall);
        end
        for (int k = 0; k < 5; k++) begin
            tick;
            PrAddr = 32'h7F04; PrWD = 32'h0;
            DevReady = (k == 4) ? 2'b10 : 2'b01;
            settle;
            checks++;
            if ({Stall, DevWE, DevSel, DevAddr, DevWD} !==
                {1'b1, 1'b1, 2'b10, 4'd8, 32'hCAFE}) begin
                errors++;
                $display("FAIL st_busy%0d got=%b%b%b %h %h exp=1110 8 cafe",
                         k, Stall, DevWE, DevSel, DevAddr, DevWD);
            end
        end
        tick; settle;
        checks++;
        if ({Stall, DataOsel, DevSel} !== 4'b0100) begin
            errors++;
            $display("FAIL st_done got=%b exp=0100", {Stall, DataOsel, DevSel});
        end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL st_sb got=empty exp=entry");
        end else begin
            exp_rd = sb.pop_front();
            last_rd = exp_rd;
            checks++;
            if (PrRD !== exp_rd) begin
                errors++;
                $display("FAIL st_rd got=%h exp=%h", PrRD, exp_rd);
            end
        end
        PrWE = 1'b0; DevReady = 2'b00;
    endtask

    task automatic test_passthrough;
        tick;
        PrRE = 1'b1; PrAddr = 32'h0040; DevReady = 2'b11;
        for (int k = 0; k < 4; k++) begin
            settle;
            checks++;
            if ({Stall, DataOsel, DevSel} !== 4'b0) begin
                errors++;
                $display("FAIL pass%0d got=%b exp=0000",
                         k, {Stall, DataOsel, DevSel});
            end
            tick;
        end
        PrRE = 1'b0; DevReady = 2'b00;
    endtask

    task automatic test_back_to_back;
        tick;
        DevReady = 2'b11;
        DevRD = {32'hB1B1_0002, 32'hA0A0_0001};
        PrRE = 1'b1; PrAddr = 32'h7F00;
        sb.push_back(32'hA0A0_0001);
        settle;
        checks++;
        if (Stall !== 1'b1) begin
            errors++;
            $display("FAIL b2b_a_idle got=%b exp=1", Stall);
        end
        tick; settle;
        checks++;
        if (DevSel !== 2'b01) begin
            errors++;
            $display("FAIL b2b_a_sel got=%b exp=01", DevSel);
        end
        tick; settle;
        checks++;
        if (DataOsel !== 1'b1) begin
            errors++;
            $display("FAIL b2b_a_done got=%b exp=1", DataOsel);
        end else begin
            exp_rd = sb.pop_front();
            checks++;
            if (PrRD !== exp_rd) begin
                errors++;
                $display("FAIL b2b_a_rd got=%h exp=%h", PrRD, exp_rd);
            end
        end
        PrAddr = 32'h7F10;
        sb.push_back(32'hB1B1_0002);
        tick; settle;
        checks++;
        if ({Stall, DataOsel, DevSel} !== 4'b1000) begin
            errors++;
            $display("FAIL b2b_b_idle got=%b exp=1000",
                     {Stall, DataOsel, DevSel});
        end
        tick; settle;
        checks++;
        if (DevSel !== 2'b10) begin
            errors++;
            $display("FAIL b2b_b_sel got=%b exp=10", DevSel);
        end
        tick; settle;
        checks++;
        if (DataOsel !== 1'b1) begin
            errors++;
            $display("FAIL b2b_b_done got=%b exp=1", DataOsel);
        end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL b2b_sb got=empty exp=entry");
        end else begin
            exp_rd = sb.pop_front();
            last_rd = exp_rd;
            checks++;
            if (PrRD !== exp_rd) begin
                errors++;
                $display("FAIL b2b_b_rd got=%h exp=%h", PrRD, exp_rd);
            end
        end
        PrRE = 1'b0;
        tick; settle;
        checks++;
        if ({Stall, DataOsel, DevSel} !== 4'b0) begin
            errors++;
            $display("FAIL b2b_after got=%b exp=0000",
                     {Stall, DataOsel, DevSel});
        end
        DevReady = 2'b00;
    endtask

    task automatic test_flush;
        tick;
        DevReady = 2'b00;
        PrRE = 1'b1; PrAddr = 32'h7F00;
        tick; settle;
        checks++;
        if (DevSel !== 2'b01) begin
            errors++;
            $display("FAIL fl_busy1 got=%b exp=01", DevSel);
        end
        tick;
        Flush = 1'b1;
        settle;
        checks++;
        if (Stall !== 1'b1) begin
            errors++;
            $display("FAIL fl_busy2 got=%b exp=1", Stall);
        end
        PrRE = 1'b0;
        tick;
        Flush = 1'b0;
        settle;
        checks++;
        if ({Stall, DataOsel, DevSel} !== 4'b0 || PrRD !== last_rd) begin
            errors++;
            $display("FAIL fl_idle got=%b rd=%h exp=0000 rd=%h",
                     {Stall, DataOsel, DevSel}, PrRD, last_rd);
        end
        tick; settle;
        checks++;
        if (DataOsel !== 1'b0) begin
            errors++;
            $display("FAIL fl_osel got=%b exp=0", DataOsel);
        end
    endtask

`ifdef BRIDGE_TIMEOUT_EN
    task automatic test_timeout;
        tick;
        PrRE = 1'b1; PrAddr = 32'h7F10; DevReady = 2'b01;
        sb.push_back(32'hDEAD_BEEF);
        for (int k = 0; k < 4; k++) begin
            tick; settle;
            checks++;
            if ({Stall, BusErr, DevSel} !== 4'b1010) begin
                errors++;
                $display("FAIL to_busy%0d got=%b exp=1010",
                         k, {Stall, BusErr, DevSel});
            end
        end
        tick; settle;
        checks++;
        if ({Stall, DataOsel, BusErr} !== 3'b011) begin
            errors++;
            $display("FAIL to_done got=%b exp=011", {Stall, DataOsel, BusErr});
        end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL to_sb got=empty exp=entry");
        end else begin
            exp_rd = sb.pop_front();
            last_rd = exp_rd;
            checks++;
            if (PrRD !== exp_rd) begin
                errors++;
                $display("FAIL to_rd got=%h exp=%h", PrRD, exp_rd);
            end
        end
        PrRE = 1'b0;
        tick; settle;
        checks++;
        if ({Stall, BusErr} !== 2'b00) begin
            errors++;
            $display("FAIL to_after got=%b exp=00", {Stall, BusErr});
        end
        DevReady = 2'b00;
    endtask
`else
    task automatic test_no_timeout;
        tick;
        PrRE = 1'b1; PrAddr = 32'h7F10; DevReady = 2'b01;
        for (int k = 0; k < 12; k++) begin
            tick; settle;
            checks++;
            if ({Stall, BusErr, DataOsel} !== 3'b100) begin
                errors++;
                $display("FAIL nto_busy%0d got=%b exp=100",
                         k, {Stall, BusErr, DataOsel});
            end
        end
        Flush = 1'b1; PrRE = 1'b0;
        tick;
        Flush = 1'b0;
        settle;
        checks++;
        if ({Stall, DataOsel} !== 2'b00) begin
            errors++;
            $display("FAIL nto_abort got=%b exp=00", {Stall, DataOsel});
        end
        DevReady = 2'b00;
    endtask
`endif

    task automatic test_reset_busy;
        tick;
        PrWE = 1'b1; PrAddr = 32'h7F14; PrWD = 32'h1111; DevReady = 2'b00;
        tick; settle;
        checks++;
        if ({DevSel, DevWE} !== 3'b101) begin
            errors++;
            $display("FAIL rb_busy got=%b exp=101", {DevSel, DevWE});
        end
        reset = 1'b1; PrWE = 1'b0;
        tick;
        reset = 1'b0;
        settle;
        checks++;
        if ({Stall, DataOsel, BusErr, DevWE, DevSel} !== 6'b0) begin
            errors++;
            $display("FAIL rb_ctl got=%b exp=000000",
                     {Stall, DataOsel, BusErr, DevWE, DevSel});
        end
        checks++;
        if ({PrRD, DevWD, DevAddr} !== 68'h0) begin
            errors++;
            $display("FAIL rb_data got=%h/%h/%h exp=0", PrRD, DevWD, DevAddr);
        end
    endtask

    initial begin
        test_reset;
        test_load_dev0;
        test_store_dev1;
        test_passthrough;
        test_back_to_back;
        test_flush;
`ifdef BRIDGE_TIMEOUT_EN
        test_timeout;
`else
        test_no_timeout;
`endif
        test_reset_busy;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
